// File: rtl/cv32e40p_clk_gate_ctrl.sv
// Core clock-gate sequencer: drains before gating on sleep, ungates on wake/debug/force,
// and acknowledges once the clock has settled. Also counts cycles spent gated.
module cv32e40p_clk_gate_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int WAKE_CYCLES  = 2,
    parameter int NUM_WAKE     = 32,
    parameter int CNT_W        = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                scan_cg_en_i,
    input  logic                sleep_req_i,
    input  logic [NUM_WAKE-1:0] wake_src_i,
    input  logic [NUM_WAKE-1:0] wake_mask_i,
    input  logic                debug_req_i,
    input  logic                force_on_i,
    input  logic                cnt_clr_i,
    output logic                clk_en_o,
    output logic                gated_o,
    output logic                wake_ack_o,
    output logic [CNT_W-1:0]    sleep_cnt_o
);

    localparam int MAXC = (DRAIN_CYCLES > WAKE_CYCLES) ? DRAIN_CYCLES : WAKE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {RUN, DRAIN, GATED, WAKE} state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic             clk_en_q;
    logic             gated_q;
    logic             ack_q;
    logic [CNT_W-1:0] sleep_cnt_q;
    logic             wake;

    assign wake = (|(wake_src_i & wake_mask_i)) | debug_req_i | force_on_i;

    // Reset lands in RUN with the clock enabled, so the core clock is never left gated.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            clk_en_q <= 1'b1;
            gated_q  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (sleep_req_i && !wake) begin
                        state_q <= DRAIN;
                        cnt_q   <= CW'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    if (wake || !sleep_req_i) begin
                        state_q <= RUN;
                    end else if (cnt_q == '0) begin
                        state_q  <= GATED;
                        clk_en_q <= 1'b0;
                        gated_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                GATED: begin
                    if (wake || !sleep_req_i) begin
                        state_q  <= WAKE;
                        cnt_q    <= CW'(WAKE_CYCLES);
                        clk_en_q <= 1'b1;
                        gated_q  <= 1'b0;
                    end
                end
                WAKE: begin
                    // Sleep requests are ignored until the settle window completes.
                    if (cnt_q == '0) begin
                        state_q <= RUN;
                        ack_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q  <= RUN;
                    clk_en_q <= 1'b1;
                    gated_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sleep_cnt_q <= '0;
        end else if (cnt_clr_i) begin
            sleep_cnt_q <= '0;
        end else if (state_q == GATED && !(&sleep_cnt_q)) begin
            sleep_cnt_q <= sleep_cnt_q + CNT_W'(1);
        end
    end

    assign clk_en_o    = clk_en_q | scan_cg_en_i;
    assign gated_o     = gated_q;
    assign wake_ack_o  = ack_q;
    assign sleep_cnt_o = sleep_cnt_q;

endmodule

// File: tb/tb_cv32e40p_clk_gate_ctrl.sv
// Scoreboard bench for cv32e40p_clk_gate_ctrl: stimulus queues per-cycle expectations,
// a negedge monitor compares outputs and checks wake_ack_o pulses against an ack queue.
module tb_cv32e40p_clk_gate_ctrl;

    localparam int NW = 32;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          scan_cg_en_i = 1'b0;
    logic          sleep_req_i = 1'b0;
    logic [NW-1:0] wake_src_i = '0;
    logic [NW-1:0] wake_mask_i = '0;
    logic          debug_req_i = 1'b0;
    logic          force_on_i = 1'b0;
    logic          cnt_clr_i = 1'b0;
    logic          clk_en_o;
    logic          gated_o;
    logic          wake_ack_o;
    logic [CW-1:0] sleep_cnt_o;

    cv32e40p_clk_gate_ctrl #(
        .DRAIN_CYCLES(4), .WAKE_CYCLES(2), .NUM_WAKE(NW), .CNT_W(CW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .scan_cg_en_i(scan_cg_en_i),
        .sleep_req_i(sleep_req_i), .wake_src_i(wake_src_i), .wake_mask_i(wake_mask_i),
        .debug_req_i(debug_req_i), .force_on_i(force_on_i), .cnt_clr_i(cnt_clr_i),
        .clk_en_o(clk_en_o), .gated_o(gated_o), .wake_ack_o(wake_ack_o),
        .sleep_cnt_o(sleep_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int            cyc;
        logic          en;
        logic          g;
        logic [CW-1:0] cnt;
        string         name;
    } exp_t;

    exp_t exp_q[$];
    int   ack_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk_i) cyc++;

    task automatic expect_at(input int c, input logic en, input logic g,
                             input int cnt, input string name);
        exp_t e;
        e.cyc = c; e.en = en; e.g = g; e.cnt = CW'(cnt); e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk_i) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (e.cyc < cyc) begin
                bad++;
                $display("FAIL %s stale expectation cyc=%0d now=%0d", e.name, e.cyc, cyc);
            end else if (clk_en_o !== e.en || gated_o !== e.g || sleep_cnt_o !== e.cnt) begin
                bad++;
                $display("FAIL %s cyc=%0d got en=%b gated=%b cnt=%0d want en=%b gated=%b cnt=%0d",
                         e.name, cyc, clk_en_o, gated_o, sleep_cnt_o, e.en, e.g, e.cnt);
            end
        end
        if (ack_q.size() > 0 && ack_q[0] == cyc) begin
            void'(ack_q.pop_front());
            total++;
            if (wake_ack_o !== 1'b1) begin
                bad++;
                $display("FAIL ack_pulse cyc=%0d got ack=%b want ack=1", cyc, wake_ack_o);
            end
        end else if (wake_ack_o !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL ack_spurious cyc=%0d got ack=%b want ack=0", cyc, wake_ack_o);
        end
    end

    initial begin
        int e0;
        int w;
        int k;

        // Reset state
        step(); step();
        expect_at(cyc, 1, 0, 0, "reset");
        step();
        rst_ni = 1'b1;
        step();

        // 1 + 3: sleep entry, masked wake ignored, debug wake with ack
        e0 = cyc + 1;
        sleep_req_i = 1'b1;
        for (int c = e0; c <= e0 + 4; c++) expect_at(c, 1, 0, 0, "drain");
        for (int c = e0 + 5; c <= e0 + 11; c++) expect_at(c, 0, 1, c - e0 - 5, "gated");
        while (cyc < e0 + 8) step();
        wake_src_i  = 32'h1;
        wake_mask_i = '0;
        step(); step(); step();
        debug_req_i = 1'b1;
        step();
        w = cyc;
        sleep_req_i = 1'b0;
        debug_req_i = 1'b0;
        wake_src_i  = '0;
        for (int c = w; c <= w + 4; c++) expect_at(c, 1, 0, 7, "wake");
        ack_q.push_back(w + 3);
        while (cyc < w + 5) step();

        // 2: drain abort by masked-in source 3, sleep+wake together holds RUN
        e0 = cyc + 1;
        sleep_req_i = 1'b1;
        for (int c = e0; c <= e0 + 8; c++) expect_at(c, 1, 0, 7, "abort");
        step(); step();
        wake_src_i  = 32'h8;
        wake_mask_i = 32'h8;
        while (cyc < e0 + 8) step();
        sleep_req_i = 1'b0;
        wake_src_i  = '0;
        wake_mask_i = '0;
        step();
        cnt_clr_i = 1'b1;
        k = cyc;
        step();
        cnt_clr_i = 1'b0;
        expect_at(k + 1, 1, 0, 0, "clr_run");
        step();

        // 4: saturation, clear while gated; 6: scan override; 5: async reset while gated
        e0 = cyc + 1;
        sleep_req_i = 1'b1;
        for (int c = e0; c <= e0 + 4; c++) expect_at(c, 1, 0, 0, "drain2");
        for (int c = e0 + 5; c <= e0 + 27; c++)
            expect_at(c, 0, 1, (c - e0 - 5 > 15) ? 15 : c - e0 - 5, "sat");
        while (cyc < e0 + 27) step();
        cnt_clr_i = 1'b1;
        step();
        cnt_clr_i = 1'b0;
        expect_at(cyc, 0, 1, 0, "clr_gated");
        step();
        scan_cg_en_i = 1'b1;
        expect_at(cyc, 1, 1, 1, "scan_on");
        step();
        scan_cg_en_i = 1'b0;
        expect_at(cyc, 0, 1, 2, "scan_off");
        step();
        #2;
        sleep_req_i = 1'b0;
        rst_ni = 1'b0;
        expect_at(cyc, 1, 0, 0, "async_rst");
        step();
        expect_at(cyc, 1, 0, 0, "rst_hold");
        rst_ni = 1'b1;
        step();
        expect_at(cyc, 1, 0, 0, "post_rst");
        step(); step(); step();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL exp_queue_drain got=%0d want=0", exp_q.size());
        end
        total++;
        if (ack_q.size() != 0) begin
            bad++;
            $display("FAIL ack_queue_drain got=%0d want=0", ack_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
